// File: rtl/add_round_key_stage_pkg.sv
// Shared AES definitions: state layout, FSM state encoding, GF(2^8) helpers,
// S-box, round constants and FIPS byte-order mapping.
package add_round_key_stage_pkg;

  // byte index = row*4 + col
  typedef logic [15:0][7:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN
  } ark_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] fips_to_state(input int unsigned k);
    return 4'(((k % 4) * 4) + (k / 4));
  endfunction

  function automatic state_t key_to_state(input logic [127:0] key);
    state_t s;
    s = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      s[fips_to_state(k)] = key[127 - 8*k -: 8];
    end
    return s;
  endfunction

endpackage

// File: rtl/key_schedule_step.sv
// One AES-128 key expansion step (combinational).
//   key_i      : current round key, state_t layout
//   rcon_i     : round constant for the key being produced
//   next_key_o : following round key, state_t layout
module key_schedule_step
  import add_round_key_stage_pkg::*;
(
  input  state_t     key_i,
  input  logic [7:0] rcon_i,
  output state_t     next_key_o
);

  logic [3:0][7:0] temp;
  logic [7:0]      acc;

  always_comb begin
    temp       = '0;
    acc        = '0;
    next_key_o = '0;
    // SubWord(RotWord(w3)): row r of temp takes row r+1 of column 3.
    for (int unsigned r = 0; r < 4; r++) begin
      temp[r] = sbox(key_i[((r + 1) % 4) * 4 + 3]) ^ ((r == 0) ? rcon_i : 8'h00);
    end
    // Each new column chains from the previous new column, row by row.
    for (int unsigned r = 0; r < 4; r++) begin
      acc = temp[r];
      for (int unsigned c = 0; c < 4; c++) begin
        acc = acc ^ key_i[r*4 + c];
        next_key_o[r*4 + c] = acc;
      end
    end
  end

endmodule

// File: rtl/add_round_key_stage.sv
// Registered AES-128 AddRoundKey stage with on-the-fly key expansion.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start, key_in       : load cipher key as round key 0 (IDLE only)
//   busy                : high outside IDLE
//   in_valid/in_ready   : input handshake, state_in
//   out_valid/out_ready : output handshake, state_out, out_round, out_last
module add_round_key_stage
  import add_round_key_stage_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  input  logic         in_valid,
  output logic         in_ready,
  input  state_t       state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output state_t       state_out,
  output logic [3:0]   out_round,
  output logic         out_last
);

  ark_state_e fsm_q, fsm_d;
  logic [3:0] cnt_q, cnt_d;
  state_t     rk_q, rk_d;
  state_t     rk_next;
  logic       ov_q, ov_d;
  state_t     data_q, data_d;
  logic [3:0] round_q, round_d;
  logic       last_q, last_d;
  logic       is_last;

  key_schedule_step u_key_step (
    .key_i      (rk_q),
    .rcon_i     (rcon(cnt_q + 4'd1)),
    .next_key_o (rk_next)
  );

  assign is_last = (cnt_q == 4'(NUM_ROUNDS));

  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    rk_d     = rk_q;
    ov_d     = ov_q;
    data_d   = data_q;
    round_d  = round_q;
    last_d   = last_q;
    in_ready = 1'b0;
    if (ov_q && out_ready) ov_d = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          rk_d  = key_to_state(key_in);
          cnt_d = '0;
          fsm_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        in_ready = !ov_q || out_ready;
        if (in_valid && in_ready) begin
          data_d  = state_in ^ rk_q;
          round_d = cnt_q;
          last_d  = is_last;
          ov_d    = 1'b1;
          if (is_last) begin
            fsm_d = ST_DRAIN;
          end else begin
            rk_d  = rk_next;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (!ov_q || out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q   <= ST_IDLE;
      cnt_q   <= '0;
      rk_q    <= '0;
      ov_q    <= 1'b0;
      data_q  <= '0;
      round_q <= '0;
      last_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      rk_q    <= rk_d;
      ov_q    <= ov_d;
      data_q  <= data_d;
      round_q <= round_d;
      last_q  <= last_d;
    end
  end

  assign busy      = (fsm_q != ST_IDLE);
  assign out_valid = ov_q;
  assign state_out = data_q;
  assign out_round = round_q;
  assign out_last  = last_q;

endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
- Registered AddRoundKey stage for AES-128 encryption that sits directly downstream of the MixColumns stage.
- Each accepted state is XORed with the current round key. The block expands the cipher key on the fly, one round key per accepted state, for rounds 0..10.
- Output goes to the next round's SubBytes or to the ciphertext sink.
- Valid/ready handshake on both sides; one output register.

Parameters:
- NUM_ROUNDS, 10, number of key-schedule steps after round 0 (AES-128 only; other values unsupported).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; loads key_in as round key 0. Honoured only in IDLE.
- key_in  in  128  cipher key, FIPS-197 byte order (bits [127:120] = key byte 0).
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  state_in is valid.
- in_ready  out  1  stage can accept state_in this cycle.
- state_in  in  state_t  state from MixColumns (or from ShiftRows/plaintext for rounds 0 and 10).
- out_valid  out  1  state_out is valid.
- out_ready  in  1  downstream accepts state_out.
- state_out  out  state_t  state_in XOR round key.
- out_round  out  4  round index (0..10) of the state in the output register.
- out_last  out  1  high when out_round == 10.

Behaviour:
- Reset values:
  - FSM = IDLE; round counter = 0; round key register = 0.
  - out_valid = 0, state_out = 0, out_round = 0, out_last = 0.
  - busy = 0, in_ready = 0.
- FSM states:
  - IDLE:
    - in_ready = 0.
    - start -> load key register with key_in (reordered into state_t layout); round counter = 0; go to ACTIVE next cycle.
  - ACTIVE:
    - in_ready = !out_valid || out_ready.
    - Transfer occurs when in_valid && in_ready.
    - On transfer: state_out <= state_in ^ round_key; out_round <= counter; out_last <= (counter == NUM_ROUNDS); out_valid <= 1.
    - On the same edge: round_key <= next_round_key(round_key, rcon[counter+1]) and counter increments.
    - On the transfer where counter == NUM_ROUNDS: go to DRAIN; the key register is not advanced.
  - DRAIN:
    - in_ready = 0.
    - Wait until the last output is accepted (out_valid && out_ready), then go to IDLE.
- Latency and throughput: one cycle from input transfer to out_valid. Full throughput of one state per cycle when out_ready stays high.
- Output register hold: if out_valid && !out_ready, state_out, out_round and out_last hold stable and in_ready = 0.
- Output drop: out_valid falls on a cycle with out_ready = 1 and no new transfer.
- Simultaneous output accept and input accept: allowed; the output register is replaced in the same cycle.
- start outside IDLE: ignored, with no effect on the key or the counter.
- start and in_valid in the same IDLE cycle: in_valid is not accepted (in_ready = 0).
- Key schedule:
  - w0..w3 are the columns of the current key.
  - temp = SubWord(RotWord(w3)) ^ {rcon, 00, 00, 00}; w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- State layout: state_t byte index = row*4 + col. FIPS byte k maps to index (k%4)*4 + k/4. The key is stored in this same layout.
- Reset mid-operation: all state returns to the reset values above on the next edge; any output in flight is discarded.
- key_in is sampled only on the cycle start is accepted.

Decomposition:
- Shared AES package receives:
  - the rcon table;
  - the S-box function;
  - the byte-index mapping function fips_to_state(k);
  - an enum type for the IDLE/ACTIVE/DRAIN states.
- state_t and the GF helpers already live there.
- Sub-module key_schedule_step: combinational; inputs key (state_t) and rcon (8); output next key (state_t). It is reused later by the decryption key path.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c; start; 11 all-zero states with out_ready = 1 -> state_out sequence equals round keys 0..10.
  - Round 1 is a0fafe1788542cb123a339392a6c7605 (FIPS order).
  - Round 10 is d014f9a8c9ee2589e13f0cc8b6630ca6.
  - out_last is high only on round 10; busy falls the cycle after the last transfer.
- FIPS-197 Appendix B: plaintext 3243f6a8885a308d313198a2e0370734 at round 0 -> state_out 193de3bea0f4e22b9ac68d2ae9f84808.
- Backpressure: hold out_ready = 0 for 3 cycles after round 2 -> in_ready = 0, state_out and out_round = 2 stable; on release, round 3 is output the next cycle with the correct key.
- start pulse during ACTIVE at round 5 -> ignored; subsequent outputs still carry round keys 6..10 of the original key.
- reset asserted at round 4 -> next cycle out_valid = 0, busy = 0, in_ready = 0; a new start with the same key restarts at round key 0.
- Back-to-back keys: second start issued the cycle after DRAIN exits to IDLE -> accepted; its round 0 output equals the second key.
